// File: rtl/ultra_net_div_seq.sv
// Sequential restoring divider: signed dividend / unsigned divisor.
// Saturated signed quotient, remainder signed like the dividend.
module ultra_net_div_seq #(
  parameter int DIVIDEND_WIDTH = 30,
  parameter int DIVISOR_WIDTH  = 12,
  parameter int QUOTIENT_WIDTH = 18
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_idle,
  output logic                       ap_ready,
  input  logic [DIVIDEND_WIDTH-1:0]  din0,
  input  logic [DIVISOR_WIDTH-1:0]   din1,
  output logic [QUOTIENT_WIDTH-1:0]  quot,
  output logic [DIVISOR_WIDTH:0]     rem,
  output logic                       sat,
  output logic                       div0
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int PW = VW + 1;
  localparam int CW = $clog2(DW);

  localparam logic [DW-1:0] POS_LIM = DW'(2**(QW-1) - 1);
  localparam logic [DW-1:0] NEG_LIM = DW'(2**(QW-1));
  localparam logic [QW-1:0] Q_MAX   = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN   = {1'b1, {(QW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic            nz_q;
  logic [DW-1:0]   a_q;
  logic [VW-1:0]   d_q;
  logic [PW-1:0]   p_q;
  logic [QW-1:0]   quot_q;
  logic [PW-1:0]   rem_q;
  logic            sat_q;
  logic            div0_q;
  logic            done_q;
  logic            idle_q;

  logic            accept;
  logic [DW-1:0]   din0_abs;
  logic [PW-1:0]   p_sh;
  logic [PW-1:0]   d_ext;
  logic            ge;
  logic [PW-1:0]   p_nx;
  logic [QW-1:0]   fq;
  logic [PW-1:0]   fr;
  logic            fs;
  logic            fz;

  // ap_idle must have been visible for a cycle before a start is taken
  assign accept   = (state_q == S_IDLE) && idle_q && ap_start;
  assign din0_abs = din0[DW-1] ? (~din0 + 1'b1) : din0;

  assign p_sh  = {p_q[PW-2:0], a_q[DW-1]};
  assign d_ext = {1'b0, d_q};
  assign ge    = (p_sh >= d_ext);
  assign p_nx  = ge ? (p_sh - d_ext) : p_sh;

  // Sign restore, clipping and divide-by-zero override for the FIX cycle
  always_comb begin
    fq = '0;
    fr = '0;
    fs = 1'b0;
    fz = 1'b0;
    if (d_q == '0) begin
      fz = 1'b1;
      fs = nz_q;
      if (nz_q) fq = neg_q ? Q_MIN : Q_MAX;
    end else if (neg_q) begin
      fs = (a_q > NEG_LIM);
      fq = fs ? Q_MIN : (~a_q[QW-1:0] + 1'b1);
      fr = ~p_q + 1'b1;
    end else begin
      fs = (a_q > POS_LIM);
      fq = fs ? Q_MAX : a_q[QW-1:0];
      fr = p_q;
    end
  end

  // Control FSM, shift/subtract datapath and registered outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      nz_q    <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      p_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      done_q <= (state_q == S_DONE);
      idle_q <= (state_q == S_IDLE) && !accept;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            neg_q   <= din0[DW-1];
            nz_q    <= |din0;
            a_q     <= din0_abs;
            d_q     <= din1;
            p_q     <= '0;
            cnt_q   <= CW'(DW - 1);
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          a_q   <= {a_q[DW-2:0], ge};
          p_q   <= p_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
          quot_q  <= fq;
          rem_q   <= fr;
          sat_q   <= fs;
          div0_q  <= fz;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ap_done  = done_q;
  assign ap_ready = done_q;
  assign ap_idle  = idle_q;
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign sat      = sat_q;
  assign div0     = div0_q;

endmodule

// File: tb/tb_ultra_net_div_seq.sv
// Directed bench for ultra_net_div_seq.
// Hand-computed vectors, latency and handshake checks.
module tb_ultra_net_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        done;
  logic        idle;
  logic        ready;
  logic [29:0] din0;
  logic [11:0] din1;
  logic [17:0] quot;
  logic [12:0] rem;
  logic        sat;
  logic        div0;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  ultra_net_div_seq dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .ap_start (start),
    .ap_done  (done),
    .ap_idle  (idle),
    .ap_ready (ready),
    .din0     (din0),
    .din1     (din1),
    .quot     (quot),
    .rem      (rem),
    .sat      (sat),
    .div0     (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One operation; optional mid-CALC start pulse and operand change
  task automatic run_op(input string tag, input int a, input int b,
                        input int eq, input int er,
                        input int es, input int ez, input bit poke);
    int n;
    int idle_hi;
    int rdy_bad;
    logic [31:0] av;
    logic [31:0] bv;
    av = a;
    bv = b;
    @(negedge clk);
    din0  = av[29:0];
    din1  = bv[11:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    n       = 0;
    idle_hi = 0;
    rdy_bad = 0;
    while (!done && n < 40) begin
      if (idle) idle_hi++;
      if (poke && n == 3) begin
        din0 = 30'h155;
        din1 = 12'h3;
      end
      if (poke && n == 10) start = 1'b1;
      if (poke && n == 11) start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    if (ready !== done) rdy_bad++;
    chk({tag, ".lat"}, n, 32);
    chk({tag, ".idle_lo"}, idle_hi, 0);
    chk({tag, ".ready"}, rdy_bad, 0);
    chk({tag, ".quot"}, $signed(quot), eq);
    chk({tag, ".rem"}, $signed(rem), er);
    chk({tag, ".sat"}, int'(sat), es);
    chk({tag, ".div0"}, int'(div0), ez);
    @(posedge clk);
    #1;
    chk({tag, ".done_1cyc"}, int'(done), 0);
    chk({tag, ".idle_back"}, int'(idle), 1);
  endtask

  initial begin
    int t0;
    int nd;
    int ndr;
    int dt[3];
    int rq[3];
    int rr[3];
    rst_n = 1'b0;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.quot", int'(quot), 0);
    chk("rst.rem", int'(rem), 0);
    chk("rst.sat", int'(sat), 0);
    chk("rst.div0", int'(div0), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.ready", int'(ready), 0);
    chk("rst.idle", int'(idle), 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("p1000_7", 1000, 7, 142, 6, 0, 0, 0);
    run_op("n1000_7", -1000, 7, -142, -6, 0, 0, 0);
    run_op("n6_4095", -6, 4095, 0, -6, 0, 0, 0);
    run_op("maxpos_1", 536870911, 1, 131071, 0, 1, 0, 0);
    run_op("minneg_1", -536870912, 1, -131072, 0, 1, 0, 0);
    run_op("edge_pos", 536735745, 4095, 131071, 0, 0, 0, 0);
    run_op("edge_neg", -131072, 1, -131072, 0, 0, 0, 0);
    run_op("over_pos", 131072, 1, 131071, 0, 1, 0, 0);
    run_op("dz_pos", 5, 0, 131071, 0, 1, 1, 0);
    run_op("dz_neg", -5, 0, -131072, 0, 1, 1, 0);
    run_op("dz_zero", 0, 0, 0, 0, 0, 1, 0);
    run_op("poke", 1000, 7, 142, 6, 0, 0, 1);

    // Reset in the middle of an operation
    @(negedge clk);
    din0  = 30'd12345;
    din1  = 12'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.quot", int'(quot), 0);
    chk("mid_rst.rem", int'(rem), 0);
    chk("mid_rst.sat", int'(sat), 0);
    chk("mid_rst.div0", int'(div0), 0);
    chk("mid_rst.idle", int'(idle), 1);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("mid_rst.no_done", nd, 0);
    run_op("after_rst", 12345, 10, 1234, 5, 0, 0, 0);

    // ap_start held high across three back-to-back operations
    @(negedge clk);
    din0  = 30'd100;
    din1  = 12'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0  = cyc;
    nd  = 0;
    ndr = 0;
    while (cyc - t0 < 110) begin
      @(posedge clk);
      #1;
      if (ready !== done) ndr++;
      if (done) begin
        if (nd < 3) begin
          dt[nd] = cyc - t0;
          rq[nd] = $signed(quot);
          rr[nd] = $signed(rem);
        end
        nd++;
        if (nd == 1) begin
          din0 = -30'sd7;
          din1 = 12'd2;
        end else if (nd == 2) begin
          din0 = 30'd0;
          din1 = 12'd9;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b.count", nd, 3);
    chk("b2b.ready", ndr, 0);
    if (nd >= 3) begin
      chk("b2b.t0", dt[0], 32);
      chk("b2b.t1", dt[1], 66);
      chk("b2b.t2", dt[2], 100);
      chk("b2b.q0", rq[0], 33);
      chk("b2b.r0", rr[0], 1);
      chk("b2b.q1", rq[1], -3);
      chk("b2b.r1", rr[1], -1);
      chk("b2b.q2", rq[2], 0);
      chk("b2b.r2", rr[2], 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
